pool_reader: RTL
================

# pool_reader

Reads the int8 HWC feature map that the conv stage writes into its output buffer (`addr = ch + ((row*DIM_IN)+col)*CH`) and applies 2x2, stride-2 max pooling. It streams the pooled results to the next layer through a valid/ready handshake. It is the consumer end of the conv output buffer: the conv datapath writes the buffer, this block walks it back out. The block sits between the conv1 output RAM and the conv2 input stage.

## Interface
Parameters:
- `DIM_IN`, 32, input map height/width; must be even.
- `CH`, 32, channels per pixel.
- `ADDR_W`, 16, buffer address width.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately.
- `start`  in  1  one-cycle request to pool the whole map; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is left.
- `done`  out  1  one-cycle pulse after the last output handshake.
- `mem_rd`  out  1  read strobe to the conv output RAM.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rdata`  in  8  signed int8 read data; valid exactly 1 cycle after `mem_rd`.
- `out_valid`  out  1  pooled sample available.
- `out_ready`  in  1  downstream accepts the sample.
- `out_data`  out  8  signed pooled value.
- `out_addr`  out  ADDR_W  destination index `ch + (r*(DIM_IN/2)+c)*CH`.

## Operation
- Iteration order, outermost first: output row `r`, output col `c`, then channel `ch`. Each counter runs from 0 to its limit minus one. `ch` is innermost, so `out_addr` increments by 1 per output.
- Each output window is read as 4 words, in order (dy,dx) = (0,0), (0,1), (1,0), (1,1).
  - Read address: `ch + ((2r+dy)*DIM_IN + 2c+dx)*CH`.
- Max register: the first returned word loads it directly; the next three update it with a signed compare (`$signed`), keeping the larger value.
- State machine states:
  - IDLE: if `start`, go to FETCH.
  - FETCH: `mem_rd`=1 for 4 consecutive cycles, window index k=0..3. After k=3, go to WAIT.
  - WAIT: one cycle; captures the last read word. Then go to OUT.
  - OUT: `out_valid`=1. When `out_valid && out_ready`, advance the counters. Go to DONE if this was the last output (r=c=DIM_IN/2-1, ch=CH-1), else go to FETCH.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `mem_rd`=0 outside FETCH. `mem_addr` is don't-care when `mem_rd`=0 but must not glitch X.
- In OUT, `out_data` and `out_addr` are held stable until the handshake completes.
- `start` while busy is ignored. Counters clear on entry to FETCH from IDLE.
- Total outputs per run: (DIM_IN/2)^2*CH, which is 8192 at default parameters.

## Timing
- Reset (`reset`=0) values: state IDLE, every counter 0, max register 0; `busy`, `done`, `mem_rd`, `out_valid` = 0; `out_data`, `out_addr`, `mem_addr` = 0.
- Reset taken mid-run aborts the run with no `done` pulse. The run restarts only on a new `start`.
- Cycle numbering for a run, with `start` high at edge 0:
  - Cycles 1-4: FETCH, `busy`=1.
  - Cycle 5: WAIT.
  - Cycle 6: first `out_valid`.
- With `out_ready` held high, throughput is one output per 6 cycles.
- Each cycle of backpressure adds one cycle to that output's period.
- `done` is asserted the cycle after the final handshake. `busy` drops together with `done` going low, and a new `start` is accepted in that IDLE cycle.

## Structure
- Shared package `pool_pkg`:
  - `DIM_IN`, `CH` defaults.
  - State enumeration (IDLE, FETCH, WAIT, OUT, DONE).
  - Window offset constants for (dy,dx).
- Sub-module `pool_addr_gen`: holds the r/c/ch/k counters and computes `mem_addr` and `out_addr` combinationally from them. It takes `clr`, `step_k`, `step_out` strobes from the FSM and reports `last_k` and `last_out`.
- The top level holds the FSM, the max register, and the output registers.

## Test plan
- Address walk with memory filled as `mem[a]=a[7:0]`: first run reads 0, 32, 1024, 1056 for ch=0; ch=1 reads 1, 33, 1025, 1057. The first `out_addr` values are 0, 1, 2.
- Signed max: window values -128, -1, 127, 0 give `out_data`=127. Window -128, -5, -3, -100 gives -3. Window all -128 gives -128 (no unsigned compare).
- Backpressure: hold `out_ready`=0 for 5 cycles on the 3rd output. `out_valid`, `out_data` and `out_addr` stay constant and no reads are issued. The run completes with exactly 8192 handshakes.
- Full run with `out_ready`=1: `done` pulses once, 8192*6+1 cycles after `start`. Compare the stream against a software max-pool of a random int8 map.
- `start` pulsed during FETCH and during OUT is ignored: the output count stays 8192 and there is only one `done`.
- `reset` asserted in the middle of the 100th output forces all outputs to 0 asynchronously. A new `start` after release restarts at `out_addr`=0 with the correct data.

Source files
------------

// File: rtl/pool_reader_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool reader: parameter defaults,
// FSM state encoding and the window-word offsets.
package pool_pkg;

  localparam int DIM_IN_DFLT = 32;
  localparam int CH_DFLT     = 32;
  localparam int ADDR_W_DFLT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_e;

  // Bit k gives (dy,dx) of window word k: (0,0), (0,1), (1,0), (1,1).
  localparam logic [3:0] WIN_DY = 4'b1100;
  localparam logic [3:0] WIN_DX = 4'b1010;

  function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                             input logic signed [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pool_reader_if.sv
// Read bus to the conv output RAM plus the pooled-sample valid/ready stream.
interface pool_reader_if #(
  parameter int ADDR_W = 16
);

  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic signed [7:0]  mem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic [ADDR_W-1:0]  out_addr;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr
  );

endinterface

// File: rtl/pool_reader_addr_gen.sv
// Output row/col/channel and window-word counters, with combinational read
// and destination addresses derived from them.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int DIM_IN = DIM_IN_DFLT,
  parameter int CH     = CH_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              step_k,
  input  logic              step_out,
  output logic [1:0]        k,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              last_k,
  output logic              last_out
);

  localparam int HALF = DIM_IN / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1;

  logic [PW-1:0] r_q, r_d, c_q, c_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [1:0]    k_q, k_d;
  logic          last_ch, last_c, last_r;
  logic [ADDR_W-1:0] row, col;

  assign last_ch  = (ch_q == CW'(CH - 1));
  assign last_c   = (c_q == PW'(HALF - 1));
  assign last_r   = (r_q == PW'(HALF - 1));
  assign last_k   = (k_q == 2'd3);
  assign last_out = last_ch && last_c && last_r;
  assign k        = k_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q  <= '0;
      c_q  <= '0;
      ch_q <= '0;
      k_q  <= '0;
    end else begin
      r_q  <= r_d;
      c_q  <= c_d;
      ch_q <= ch_d;
      k_q  <= k_d;
    end
  end

  // Channel innermost, then column, then row; everything wraps to 0 after the last output.
  always_comb begin
    r_d  = r_q;
    c_d  = c_q;
    ch_d = ch_q;
    k_d  = k_q;
    if (clr) begin
      r_d  = '0;
      c_d  = '0;
      ch_d = '0;
      k_d  = '0;
    end else begin
      if (step_k) k_d = k_q + 2'd1;
      if (step_out) begin
        if (last_ch) begin
          ch_d = '0;
          if (last_c) begin
            c_d = '0;
            r_d = last_r ? '0 : r_q + PW'(1);
          end else begin
            c_d = c_q + PW'(1);
          end
        end else begin
          ch_d = ch_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    row      = ADDR_W'({r_q, 1'b0}) + ADDR_W'(WIN_DY[k_q]);
    col      = ADDR_W'({c_q, 1'b0}) + ADDR_W'(WIN_DX[k_q]);
    mem_addr = ADDR_W'(ch_q) + (row * ADDR_W'(DIM_IN) + col) * ADDR_W'(CH);
    out_addr = ADDR_W'(ch_q)
             + (ADDR_W'(r_q) * ADDR_W'(HALF) + ADDR_W'(c_q)) * ADDR_W'(CH);
  end

endmodule

// File: rtl/pool_reader.sv
// Walks the conv output buffer in 2x2 windows and streams the signed max of
// each window, one channel at a time, over a valid/ready handshake.
module pool_reader
  import pool_pkg::*;
#(
  parameter int DIM_IN = DIM_IN_DFLT,
  parameter int CH     = CH_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  pool_reader_if.master bus
);

  state_e            state_q, state_d;
  logic signed [7:0] max_q, max_d;
  logic              clr, step_k, step_out, last_k, last_out;
  logic [1:0]        k;
  logic [ADDR_W-1:0] mem_addr, out_addr;

  pool_addr_gen #(
    .DIM_IN (DIM_IN),
    .CH     (CH),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .step_k   (step_k),
    .step_out (step_out),
    .k        (k),
    .mem_addr (mem_addr),
    .out_addr (out_addr),
    .last_k   (last_k),
    .last_out (last_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
    end
  end

  // Read data lags the strobe by one cycle: FETCH k=1 sees word 0, WAIT sees word 3.
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    clr      = 1'b0;
    step_k   = 1'b0;
    step_out = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        step_k = 1'b1;
        if (k == 2'd1)      max_d = bus.mem_rdata;
        else if (k != 2'd0) max_d = smax(max_q, bus.mem_rdata);
        if (last_k) state_d = S_WAIT;
      end
      S_WAIT: begin
        max_d   = smax(max_q, bus.mem_rdata);
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          step_out = 1'b1;
          state_d  = last_out ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign bus.mem_rd    = (state_q == S_FETCH);
  assign bus.mem_addr  = mem_addr;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = max_q;
  assign bus.out_addr  = out_addr;

endmodule
